// File: rtl/sw_count_seq_if.sv
// Control inputs and display/status outputs of the stopwatch time-base sequencer.
interface sw_count_seq_if;
  logic       init_regs;
  logic       count_enabled;
  logic       split;
  logic [3:0] tenths;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic       frozen;
  logic       tick;
  logic       wrap;

  modport master (
    output init_regs, count_enabled, split,
    input  tenths, sec_ones, sec_tens, frozen, tick, wrap
  );

  modport slave (
    input  init_regs, count_enabled, split,
    output tenths, sec_ones, sec_tens, frozen, tick, wrap
  );
endinterface

// File: rtl/sw_count_seq.sv
// Stopwatch time base: 0.1 s prescaler, 59.9 s BCD digit chain and split display hold.
//   state  | meaning
//   LIVE   | display follows the running digits
//   FROZEN | display shows the held split value; live count keeps running
module sw_count_seq #(
  parameter int DIV = 10_000_000,
  parameter int PW  = 24
) (
  input  logic          clk,
  input  logic          reset,
  sw_count_seq_if.slave bus
);

  localparam logic [PW-1:0] PRE_TC = PW'(DIV - 1);

  typedef enum logic {LIVE, FROZEN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q;
  logic [3:0]    tenths_q, ones_q, tens_q;
  logic [3:0]    tenths_d, ones_d, tens_d;
  logic [3:0]    hold_tenths_q, hold_ones_q, hold_tens_q;
  logic          tick_q, wrap_q;
  logic          adv, at_max, capture;

  assign adv    = bus.count_enabled && (pre_q == PRE_TC);
  assign at_max = (tenths_q == 4'd9) && (ones_q == 4'd9) && (tens_q == 4'd5);

  always_comb begin
    tenths_d = tenths_q;
    ones_d   = ones_q;
    tens_d   = tens_q;
    if (tenths_q == 4'd9) begin
      tenths_d = 4'd0;
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = (tens_q == 4'd5) ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else begin
      tenths_d = tenths_q + 4'd1;
    end
  end

  // Split is only honoured while counting; a paused split belongs to Ctl.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (bus.init_regs) begin
      state_d = LIVE;
    end else begin
      case (state_q)
        LIVE: begin
          if (bus.split && bus.count_enabled) begin
            state_d = FROZEN;
            capture = 1'b1;
          end
        end
        FROZEN: begin
          if (bus.split) state_d = LIVE;
        end
        default: state_d = LIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= LIVE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q         <= '0;
      tenths_q      <= '0;
      ones_q        <= '0;
      tens_q        <= '0;
      hold_tenths_q <= '0;
      hold_ones_q   <= '0;
      hold_tens_q   <= '0;
      tick_q        <= 1'b0;
      wrap_q        <= 1'b0;
    end else if (bus.init_regs) begin
      pre_q         <= '0;
      tenths_q      <= '0;
      ones_q        <= '0;
      tens_q        <= '0;
      hold_tenths_q <= '0;
      hold_ones_q   <= '0;
      hold_tens_q   <= '0;
      tick_q        <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      tick_q <= adv;
      wrap_q <= adv && at_max;
      if (bus.count_enabled) begin
        if (pre_q == PRE_TC) begin
          pre_q    <= '0;
          tenths_q <= tenths_d;
          ones_q   <= ones_d;
          tens_q   <= tens_d;
        end else begin
          pre_q <= pre_q + PW'(1);
        end
      end
      // Hold takes the pre-increment digits, so a split on the wrap edge keeps 59.9.
      if (capture) begin
        hold_tenths_q <= tenths_q;
        hold_ones_q   <= ones_q;
        hold_tens_q   <= tens_q;
      end
    end
  end

  assign bus.frozen   = (state_q == FROZEN);
  assign bus.tenths   = (state_q == FROZEN) ? hold_tenths_q : tenths_q;
  assign bus.sec_ones = (state_q == FROZEN) ? hold_ones_q   : ones_q;
  assign bus.sec_tens = (state_q == FROZEN) ? hold_tens_q   : tens_q;
  assign bus.tick     = tick_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_sw_count_seq.sv
// Scoreboard bench for sw_count_seq at DIV = 4: stimulus queues expected outputs, monitor checks them.
module tb_sw_count_seq;

  logic clk;
  logic reset;

  sw_count_seq_if bus ();

  sw_count_seq #(.DIV(4), .PW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] t;
    logic [3:0] o;
    logic [3:0] s;
    logic       fr;
    logic       tk;
    logic       wr;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Behavioural reference: live value in tenths of a second (0..599).
  int   m_pre, m_live, m_hold;
  bit   m_fr, m_tk, m_wr;

  task automatic model_clear();
    m_pre = 0; m_live = 0; m_hold = 0; m_fr = 0; m_tk = 0; m_wr = 0;
  endtask

  task automatic model_edge(input bit i, input bit e, input bit s);
    if (i) begin
      model_clear();
    end else begin
      m_tk = 0;
      m_wr = 0;
      if (!m_fr && s && e) begin
        m_hold = m_live;
        m_fr   = 1;
      end else if (m_fr && s) begin
        m_fr = 0;
      end
      if (e) begin
        if (m_pre == 3) begin
          m_pre  = 0;
          m_live = (m_live + 1) % 600;
          m_tk   = 1;
          m_wr   = (m_live == 0);
        end else begin
          m_pre++;
        end
      end
    end
  endtask

  function automatic exp_t model_exp(input string nm);
    exp_t x;
    int   v;
    v    = m_fr ? m_hold : m_live;
    x.t  = 4'(v % 10);
    x.o  = 4'((v / 10) % 10);
    x.s  = 4'(v / 100);
    x.fr = m_fr;
    x.tk = m_tk;
    x.wr = m_wr;
    x.nm = nm;
    return x;
  endfunction

  task automatic drive(input bit i, input bit e, input bit s);
    @(negedge clk);
    bus.init_regs     = i;
    bus.count_enabled = e;
    bus.split         = s;
  endtask

  task automatic step(input bit i, input bit e, input bit s, input string nm);
    drive(i, e, s);
    model_edge(i, e, s);
    q.push_back(model_exp(nm));
  endtask

  // Directed vector with a hand-computed expectation (model kept in step).
  task automatic step_x(input bit i, input bit e, input bit s,
                        input logic [3:0] t, input logic [3:0] o, input logic [3:0] sx,
                        input bit fr, input bit tk, input bit wr, input string nm);
    exp_t x;
    drive(i, e, s);
    model_edge(i, e, s);
    x.t = t; x.o = o; x.s = sx; x.fr = fr; x.tk = tk; x.wr = wr; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic run(input int n, input string nm);
    for (int k = 0; k < n; k++) step(0, 1, 0, nm);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      while (q.size() > 0) begin
        x = q.pop_front();
        n_vec++;
        if (bus.tenths !== x.t || bus.sec_ones !== x.o || bus.sec_tens !== x.s ||
            bus.frozen !== x.fr || bus.tick !== x.tk || bus.wrap !== x.wr) begin
          n_fail++;
          $display("FAIL %s: got %0h%0h.%0h fr=%0b tk=%0b wr=%0b, want %0h%0h.%0h fr=%0b tk=%0b wr=%0b",
                   x.nm, bus.sec_tens, bus.sec_ones, bus.tenths, bus.frozen, bus.tick, bus.wrap,
                   x.s, x.o, x.t, x.fr, x.tk, x.wr);
        end
      end
    end
  end

  initial begin : stimulus
    exp_t z;
    z.t = 0; z.o = 0; z.s = 0; z.fr = 0; z.tk = 0; z.wr = 0;

    reset             = 1'b0;
    bus.init_regs     = 1'b0;
    bus.count_enabled = 1'b0;
    bus.split         = 1'b0;
    model_clear();
    z.nm = "reset_state";
    q.push_back(z);
    @(negedge clk);
    reset = 1'b1;
    step_x(1, 0, 0, 0, 0, 0, 0, 0, 0, "init_after_reset");

    // Run: ticks every 4th cycle, 1.0 after 40 cycles
    run(39, "run");
    step_x(0, 1, 0, 0, 1, 0, 0, 1, 0, "run_40");

    // Count on to 3.7 then assert async reset between edges
    run(107, "to_3_7");
    step_x(0, 1, 0, 7, 3, 0, 0, 1, 0, "at_3_7");
    @(negedge clk);
    #2;
    z.nm = "async_reset";
    q.push_back(z);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    step_x(1, 0, 0, 0, 0, 0, 0, 0, 0, "clear_after_reset");

    // Pause keeps the partial prescaler period
    run(5, "pause_en");
    step_x(0, 1, 0, 1, 0, 0, 0, 0, 0, "pause_6");
    for (int k = 0; k < 10; k++) step(0, 0, 0, "paused");
    step_x(0, 1, 0, 1, 0, 0, 0, 0, 0, "resume_1");
    step_x(0, 1, 0, 2, 0, 0, 0, 1, 0, "resume_2");

    // Wrap after 2400 enabled cycles
    step(1, 0, 0, "wrap_clear");
    run(2398, "wrap_run");
    step_x(0, 1, 0, 9, 9, 5, 0, 0, 0, "pre_wrap");
    step_x(0, 1, 0, 0, 0, 0, 0, 1, 1, "wrap");
    step_x(0, 1, 0, 0, 0, 0, 0, 0, 0, "post_wrap");

    // Split freeze / release
    step(1, 0, 0, "split_clear");
    run(91, "split_run");
    step_x(0, 1, 0, 3, 2, 0, 0, 1, 0, "live_2_3");
    step_x(0, 1, 1, 3, 2, 0, 1, 0, 0, "freeze");
    run(19, "frozen_run");
    step_x(0, 1, 0, 3, 2, 0, 1, 0, 0, "frozen_hold");
    step_x(0, 1, 1, 8, 2, 0, 0, 0, 0, "release");
    step_x(0, 0, 1, 8, 2, 0, 0, 0, 0, "split_paused");
    step(0, 0, 0, "split_paused_after");

    // Clear beats split while frozen
    step_x(0, 1, 1, 8, 2, 0, 1, 0, 0, "refreeze");
    step_x(1, 1, 1, 0, 0, 0, 0, 0, 0, "clear_vs_split");
    step(0, 1, 0, "after_clear");

    // Split on the wrap edge holds 59.9
    step(1, 0, 0, "sw_clear");
    run(2399, "sw_run");
    step_x(0, 1, 1, 9, 9, 5, 1, 1, 1, "split_on_wrap");
    step_x(0, 1, 1, 0, 0, 0, 0, 0, 0, "release_after_wrap");

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_count_seq.md
# sw_count_seq

Time-base and digit sequencer for the stopwatch counting datapath. It sits between the `Ctl` state machine and the seven-segment display path. It turns `Ctl`'s `init_regs` / `count_enabled` controls into a 0.1 s prescaled tick, runs the tenths / seconds / tens-of-seconds BCD chain, and implements the split (lap-freeze) display hold. The live count keeps running while the display is frozen.

## Interface
- `DIV`, default 10_000_000: clock cycles per 0.1 s tick; legal range ≥ 1.
- `PW`, default 24: prescaler width; must satisfy 2^PW ≥ DIV.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-low reset; forces every register to its reset value immediately.
- `init_regs`  in  1: synchronous clear from `Ctl`; has highest synchronous priority.
- `count_enabled`  in  1: advance enable from `Ctl`.
- `split`  in  1: one-cycle, already-debounced split request.
- `tenths`  out  4: displayed tenths digit, 0–9.
- `sec_ones`  out  4: displayed seconds-units digit, 0–9.
- `sec_tens`  out  4: displayed seconds-tens digit, 0–5.
- `frozen`  out  1: 1 while the display shows held split values.
- `tick`  out  1: registered one-cycle pulse, high in the cycle a new live tenths value first appears.
- `wrap`  out  1: registered one-cycle pulse, high together with `tick` when the live count rolls from 59.9 to 00.0.

## Operation
- **Reset values.** Prescaler = 0, live digits = 0, hold digits = 0, `frozen` = 0, `tick` = 0, `wrap` = 0. All outputs therefore read 0.
- **Clear priority.** When `init_regs` = 1, the next edge clears the prescaler, live digits, hold digits, `frozen`, `tick` and `wrap`. `count_enabled` and `split` are ignored in that cycle.
- **Prescaler.**
  - Increments only when `count_enabled` = 1 and `init_regs` = 0.
  - When it is at DIV-1 and enabled, the next edge sets it to 0, advances the live digits, and sets `tick` = 1.
  - `tick` = 0 on every other edge.
- **Pause.** When `count_enabled` = 0, the prescaler and digits hold their values. A partial period is not discarded: the count resumes where it stopped.
- **Digit chain** (advances only on a tick):
  - `tenths` 9→0 carries into `sec_ones`.
  - `sec_ones` 9→0 carries into `sec_tens`.
  - `sec_tens` 5→0 with all lower digits at 9 produces 00.0 and sets `wrap` = 1 for one cycle.
  - Digits never leave their legal ranges.
- **Freeze FSM, states LIVE and FROZEN** (reset state LIVE):
  - LIVE, `split` = 1 and `count_enabled` = 1 → FROZEN. The hold registers capture the live digits as they are presented in that cycle, i.e. before any increment on the same edge.
  - LIVE, `split` = 1 and `count_enabled` = 0 → stay in LIVE; no capture. In this case `Ctl` is handling the split as PAUSED→IDLE.
  - FROZEN, `split` = 1 → LIVE, regardless of `count_enabled`.
  - Either state, `init_regs` = 1 → LIVE.
- **Display mux.** The display outputs show the hold registers in FROZEN and the live digits in LIVE. `frozen` = 1 exactly in FROZEN.
- **Unaffected by freeze.** The live count, `tick` and `wrap` keep running in FROZEN.

## Timing
- **Tick latency.** From a clear with `count_enabled` held at 1, the first `tick` is high in cycle DIV after the clear, and `tenths` = 1 in that same cycle.
- **DIV = 1.** `tick` pulses on every enabled cycle.
- **Freeze and release latency.** The display switches one cycle after the `split` sample, for both freeze and release. On release, the outputs show the current live value immediately.
- **Split coinciding with wrap.** Captures the pre-wrap value, 59.9.
- **Reset mid-operation.** Asynchronous assertion clears everything immediately. After release, the block behaves as if just cleared.
- **Interface type.** No handshakes; all inputs are sampled on every edge.

## Test plan
All scenarios use `DIV` = 4.

- **Reset:** hold `reset` = 0 mid-count at 3.7 → all outputs 0 with no clock edge. Release, then 1 cycle of `init_regs` → outputs remain 00.0, `frozen` = 0.
- **Run:** `count_enabled` = 1 for 40 cycles after a clear → `tick` on cycles 4, 8, …, 40; final display 1.0; `tick` is never high in two consecutive cycles.
- **Pause:** enable 6 cycles (display 0.1), disable 10 cycles (display holds 0.1, no tick), enable 2 cycles → `tick` on the second cycle, display 0.2.
- **Wrap:** 2400 enabled cycles from a clear → display 00.0 with `tick` = `wrap` = 1 in the same cycle. Cycle 2399 shows 59.9; `wrap` is never high otherwise.
- **Split:**
  - At live 2.3, pulse `split` → `frozen` = 1 and display 2.3.
  - Continue 20 cycles → display stays 2.3, live advances to 2.8.
  - Pulse `split` → `frozen` = 0 and display 2.8 next cycle.
  - With `count_enabled` = 0, pulse `split` in LIVE → no freeze.
- **Clear vs split:** in FROZEN, assert `init_regs` and `split` in the same cycle → next cycle all digits 0, `frozen` = 0, no re-freeze.
